// File: rtl/cpu_param_pkg.sv
// cpu_param_pkg: instruction field constants, FSM states and illegal-encoding decode
// shared by the cpu_param core.
package cpu_param_pkg;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;

    localparam logic [1:0] SH_LSL = 2'b01;
    localparam logic [1:0] SH_LSR = 2'b10;
    localparam logic [1:0] SH_ASR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WB
    } state_t;

    // MOV reg requires its Rn field to be zero; every ALU op code is defined
    function automatic logic is_illegal(input logic [15:0] ir);
        return !((ir[15:13] == OPC_ALU) ||
                 (ir[15:13] == OPC_MOV && ir[12:11] == OP_MOVI) ||
                 (ir[15:13] == OPC_MOV && ir[12:11] == OP_MOVR && ir[10:8] == 3'b000));
    endfunction

endpackage

// File: rtl/cpu_param_iqueue.sv
// cpu_param_iqueue: synchronous FIFO buffering instructions ahead of IR;
// pushes while full and pops while empty are ignored.
module cpu_param_iqueue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_q];

    always_comb begin
        wr_d  = do_push ? wr_q + 1'b1 : wr_q;
        rd_d  = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/cpu_param.sv
// cpu_param: parametrised multi-cycle CPU core (MOV imm/reg, ADD, CMP, AND, MVN).
// Define CPU_PARAM_IQUEUE_EN to place an IQ_DEPTH-entry FIFO in front of IR.
module cpu_param
    import cpu_param_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int IQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [15:0]       in,
    output logic              in_ready,
    output logic [DATA_W-1:0] out,
    output logic              N,
    output logic              V,
    output logic              Z,
    output logic              w,
    output logic              err
);
    state_t            state_q, state_d;
    logic [15:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [DATA_W-1:0] regs_q [8];
    logic [DATA_W-1:0] regs_d [8];
    logic              n_q, n_d, v_q, v_d, z_q, z_d, err_q, err_d;
    logic              head_valid;
    logic [15:0]       head;

`ifdef CPU_PARAM_IQUEUE_EN
    logic full, empty;

    cpu_param_iqueue #(.DEPTH(IQ_DEPTH), .WIDTH(16)) u_iqueue (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .din   (in),
        .pop   (state_q == S_IDLE),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign in_ready   = !full;
    assign head_valid = !empty;
    assign w          = (state_q == S_IDLE) && empty;
`else
    assign head       = in;
    assign head_valid = in_valid;
    assign in_ready   = (state_q == S_IDLE);
    assign w          = (state_q == S_IDLE);
`endif

    logic [2:0]        rn, rd, rm;
    logic [1:0]        sh, op;
    logic              is_mov, is_movi, is_cmp;
    logic [DATA_W-1:0] shb, alu;

    assign rn      = ir_q[10:8];
    assign rd      = ir_q[7:5];
    assign sh      = ir_q[4:3];
    assign rm      = ir_q[2:0];
    assign op      = ir_q[12:11];
    assign is_mov  = ir_q[15:13] == OPC_MOV;
    assign is_movi = is_mov && op == OP_MOVI;
    assign is_cmp  = !is_mov && op == OP_CMP;

    assign shb = sh == SH_LSL ? b_q << 1 :
                 sh == SH_LSR ? b_q >> 1 :
                 sh == SH_ASR ? {b_q[DATA_W-1], b_q[DATA_W-1:1]} : b_q;
    assign alu = is_movi       ? DATA_W'($signed(ir_q[7:0])) :
                 is_mov        ? shb :
                 op == OP_ADD  ? a_q + shb :
                 op == OP_CMP  ? a_q - shb :
                 op == OP_AND  ? a_q & shb : ~shb;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        regs_d  = regs_q;
        n_d     = n_q;
        v_d     = v_q;
        z_d     = z_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (head_valid) begin
                    ir_d    = head;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                err_d   = is_illegal(ir_q);
                state_d = err_d ? S_IDLE : is_movi ? S_EXEC :
                          (is_mov || op == 2'b11) ? S_RD_B : S_RD_A;
            end
            S_RD_A: begin
                a_d     = regs_q[rn];
                state_d = S_RD_B;
            end
            S_RD_B: begin
                b_d     = regs_q[rm];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                c_d     = alu;
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
                if (is_cmp) begin
                    n_d = c_q[DATA_W-1];
                    z_d = c_q == '0;
                    // a_q and b_q are still held, so overflow is rebuilt from the operands
                    v_d = (a_q[DATA_W-1] ^ shb[DATA_W-1]) & (c_q[DATA_W-1] ^ a_q[DATA_W-1]);
                end else begin
                    regs_d[is_movi ? rn : rd] = c_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            n_q     <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            n_q     <= n_d;
            v_q     <= v_d;
            z_q     <= z_d;
            err_q   <= err_d;
            regs_q  <= regs_d;
        end
    end

    assign out = c_q;
    assign N   = n_q;
    assign V   = v_q;
    assign Z   = z_q;
    assign err = err_q;

endmodule

// File: doc/cpu_param.md
# cpu_param

Parametrised multi-cycle CPU core: the successor to the 16-bit lab CPU. It executes the same 16-bit instruction encoding (MOV imm, MOV reg, ADD, CMP, AND, MVN) on a DATA_W-bit datapath with eight registers. Instructions arrive over a valid/ready handshake into an optional instruction queue. Unrecognised encodings are reported with an error pulse. It sits between the instruction source (bench or fetch unit) and the status/result consumers.

## Interface
- DATA_W, 16, datapath/register width; legal range 8..32.
- IQ_DEPTH, 4, instruction queue entries (power of 2, ≥2); only used with the queue compiled in.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; when low, all state is cleared immediately.
- in_valid  in  1  an instruction is offered on `in`.
- in  in  16  instruction word.
- in_ready  out  1  the core accepts `in`; a transfer occurs on the edge where in_valid && in_ready.
- out  out  DATA_W  C result register (last EXEC value).
- N, V, Z  out  1 each  status flags.
- w  out  1  waiting: idle with no pending instruction.
- err  out  1  one-cycle pulse after an illegal instruction is decoded.

## Operation
- Instruction encoding:
  - `110_10_Rn_im8`: MOV Rn, #sx(im8).
  - `110_00_000_Rd_sh_Rm`: MOV Rd, Rm{sh}.
  - `101_00`: ADD Rd = Rn + Rm{sh}.
  - `101_01`: CMP Rn − Rm{sh}; updates flags only.
  - `101_10`: AND Rd = Rn & Rm{sh}.
  - `101_11`: MVN Rd = ~Rm{sh}.
  - Any other encoding is illegal.
- Shift field sh:
  - 00: none.
  - 01: LSL 1.
  - 10: LSR 1 (MSB ← 0).
  - 11: ASR 1 (MSB kept).
- Immediates: im8 is sign-extended to DATA_W.
- Arithmetic: all modulo 2^DATA_W.
- Flags: updated only by CMP.
  - N = result MSB.
  - Z = (result == 0).
  - V = signed overflow of the subtraction.
- FSM states:
  - IDLE: pops the head instruction into IR if one is available.
  - DECODE.
  - RD_A: A ← R[Rn].
  - RD_B: B ← R[Rm].
  - EXEC: C ← ALU(A, shift(B)), or sx(im8).
  - WB: R[Rd or Rn] ← C, or flags ← ALU status for CMP.
- State paths, counted from DECODE:
  - MOV imm: DECODE → EXEC → WB (3 cycles).
  - MOV reg and MVN: DECODE → RD_B → EXEC → WB (4 cycles).
  - ADD, AND, CMP: DECODE → RD_A → RD_B → EXEC → WB (5 cycles).
  - Illegal: DECODE → IDLE; err is high in the following cycle and no architectural state changes.
  - WB always returns to IDLE.
- Reset values: R0–R7 = 0, out = 0, N = V = Z = 0, err = 0, FSM = IDLE, queue empty.

## Timing
- w is combinational: (state == IDLE) && no instruction is pending. It is 1 during reset and from the first cycle after reset.
- Pop: happens in IDLE; DECODE follows on the next cycle.
- in_ready is registered-state based; there is no combinational path from in_valid.
- Queue full: in_ready = 0. There is no bypass, so a push and pop in the same cycle on a full queue does not accept the push.
- Queue empty: a push becomes visible to IDLE in the next cycle.
- A push and pop in the same cycle leaves the count unchanged.
- Reset asserted mid-instruction: the instruction is abandoned, queue contents are dropped, and all outputs return to their reset values asynchronously.

## Configuration
- `CPU_PARAM_IQUEUE_EN` defined: an IQ_DEPTH-entry FIFO sits in front of IR, and in_ready = !full.
- Not defined: IR is the only buffer, in_ready = (state == IDLE), and w = (state == IDLE). The instruction is captured directly into IR, and DECODE follows on the next cycle.
- Instruction semantics and latencies after DECODE are identical in both builds.

## Structure
- `cpu_param_pkg`: opcode/op constants, shift encodings, FSM state enum, and the illegal-decode function.
- Sub-module `cpu_param_iqueue`: a parametrised synchronous FIFO (DEPTH, WIDTH=16) with full/empty outputs and async active-low reset. It is instantiated only under the macro.

## Test plan
- MOV sequence, DATA_W=16: MOV R2,#0x33; MVN R5,R2,ASR#1 → R5 = 0xFFE6. Then MOV R3,#2; ADD R0,R2,R3,LSL#1 → R0 = 0x0037 and out = 0x0037.
- Flags, DATA_W=16: MOV R6,#0x37; CMP R6,R0 → Z=1, N=0, V=0, and R0 is unchanged. MOV R7,#0; MOV R3,#0x20; CMP R7,R3,LSR#1 → N=1, Z=0, V=0.
- Overflow, DATA_W=8: MOV R1,#0x80; MOV R2,#1; CMP R1,R2 → V=1, N=0, Z=0. MOV R4,#0xFF → R4 = 0xFF.
- Queue backpressure, macro on, IQ_DEPTH=4: hold in_valid from reset with six MOV-imm instructions. in_ready first drops after exactly 5 accepts. All six instructions retire in order and w=1 at the end.
- Illegal: offer 16'hE000 → err is high for exactly one cycle, and registers, flags and out are unchanged. The next legal instruction then executes normally.
- Reset mid-op: drop reset during the RD_B of an ADD → out = 0, all registers = 0, w = 1 in the same cycle. No write-back occurs after reset is released.
